// File: rtl/reg_file_bist.sv
// Built-in self-test master for the register file: writes a two-pass address/inverse-address
// pattern, reads it back on both ports, and reports pass/fail with the first failing address.
module reg_file_bist #(
  parameter int data_width = 32,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  we,
  output logic [addr_width-1:0] wr_addr,
  output logic [data_width-1:0] wr_data,
  output logic [addr_width-1:0] read_addr1,
  output logic [addr_width-1:0] read_addr2,
  input  logic [data_width-1:0] read_data1,
  input  logic [data_width-1:0] read_data2,
  output logic                  busy,
  output logic                  done,
  output logic                  pass_ok,
  output logic [addr_width-1:0] fail_addr,
  output logic                  fail_port
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [addr_width-1:0] LAST_INDEX = '1;
  localparam logic [addr_width-1:0] ONE        = addr_width'(1);

  state_t                r_state;
  state_t                w_nextState;
  logic [addr_width-1:0] r_index;
  logic                  r_pass;
  logic                  r_failFlag;
  logic [addr_width-1:0] r_failAddr;
  logic                  r_failPort;

  logic                  w_lastIndex;
  logic [addr_width-1:0] w_mirrorIndex;
  logic                  w_mismatch1;
  logic                  w_mismatch2;

  // Pattern value: zero-extended address, inverted on the second pass.
  function automatic logic [data_width-1:0] expected(input logic [addr_width-1:0] a,
                                                     input logic p);
    logic [data_width-1:0] v;
    v = '0;
    v[addr_width-1:0] = a;
    return p ? ~v : v;
  endfunction

  // Port 2 walks the array downward, so N-1-i is just the bitwise complement of i.
  assign w_lastIndex   = (r_index == LAST_INDEX);
  assign w_mirrorIndex = ~r_index;
  assign w_mismatch1   = (r_state == READ) && (read_data1 != expected(r_index, r_pass));
  assign w_mismatch2   = (r_state == READ) && (read_data2 != expected(w_mirrorIndex, r_pass));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_nextState = WRITE;
      WRITE:      if (w_lastIndex) w_nextState = READ;
      READ:       if (w_lastIndex) w_nextState = r_pass ? DONE : WRITE;
      default:    w_nextState = IDLE;
    endcase
  end

  // Index, pass and sticky first-failure capture; port 1 wins a same-cycle tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_index    <= '0;
      r_pass     <= 1'b0;
      r_failFlag <= 1'b0;
      r_failAddr <= '0;
      r_failPort <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_index    <= '0;
            r_pass     <= 1'b0;
            r_failFlag <= 1'b0;
            r_failAddr <= '0;
            r_failPort <= 1'b0;
          end
        end
        WRITE: r_index <= r_index + ONE;
        READ: begin
          r_index <= r_index + ONE;
          if (w_lastIndex && !r_pass) r_pass <= 1'b1;
          if ((w_mismatch1 || w_mismatch2) && !r_failFlag) begin
            r_failFlag <= 1'b1;
            r_failAddr <= w_mismatch1 ? r_index : w_mirrorIndex;
            r_failPort <= !w_mismatch1;
          end
        end
        default: r_index <= '0;
      endcase
    end
  end

  always_comb begin
    we         = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    read_addr1 = '0;
    read_addr2 = '0;
    busy       = 1'b0;
    done       = 1'b0;
    pass_ok    = 1'b0;
    fail_addr  = r_failAddr;
    fail_port  = r_failPort;
    case (r_state)
      WRITE: begin
        we      = 1'b1;
        wr_addr = r_index;
        wr_data = expected(r_index, r_pass);
        busy    = 1'b1;
      end
      READ: begin
        read_addr1 = r_index;
        read_addr2 = w_mirrorIndex;
        busy       = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        pass_ok = !r_failFlag;
      end
      default: ;
    endcase
  end

endmodule
